ui_char_seq_mc: RTL and testbench

Multi-channel, parametrised character sequencer between NUM_CH character FIFOs and a single UART transmitter in the ui subsystem. It arbitrates round-robin among non-empty, enabled FIFOs and pops one character per grant. It presents the character with its source channel index to the transmitter and holds it until the rising edge of tx_done. It supports standard FIFOs (configurable read latency) and first-word-fall-through FIFOs, plus an optional inter-character idle gap.

---
 rtl/ui_char_seq_mc.sv | 182 ++++++++++++++++++
 tb/tb_ui_char_seq_mc.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ui_char_seq_mc.sv
// ui_char_seq_mc: round-robin character sequencer from NUM_CH FIFOs to one UART TX.
// Pops one character per grant, presents it with its channel index and holds it
// until the rising edge of tx_done, then optionally idles GAP_CYC cycles.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ch_enable           per-channel enable (sampled only while arbitrating)
//   ch_fifo_empty       per-channel FIFO empty flags
//   ch_fifo_rd_en       per-channel one-cycle pop strobe (registered)
//   ch_fifo_dout        packed FIFO data, channel i at [i*DATA_W +: DATA_W]
//   tx_data_val/tx_data/tx_ch  character, valid and source channel to the UART
//   tx_done             UART completion; rising edge accepts the character
//   busy                high whenever the sequencer is not idle
module ui_char_seq_mc #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned FWFT    = 0,
   parameter int unsigned RD_LAT  = 1,
   parameter int unsigned GAP_CYC = 0,
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH-1:0]          ch_enable,
   input  logic [NUM_CH-1:0]          ch_fifo_empty,
   output logic [NUM_CH-1:0]          ch_fifo_rd_en,
   input  logic [NUM_CH*DATA_W-1:0]   ch_fifo_dout,
   output logic                       tx_data_val,
   output logic [DATA_W-1:0]          tx_data,
   output logic [CH_W-1:0]            tx_ch,
   input  logic                       tx_done,
   output logic                       busy
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_SEND  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [NUM_CH-1:0]   r_rd_en, w_rd_en_nxt;
   logic                r_val, w_val_nxt;
   logic [DATA_W-1:0]   r_data, w_data_nxt;
   logic [CH_W-1:0]     r_ch, w_ch_nxt;
   logic [CH_W-1:0]     r_rr, w_rr_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic                r_busy;
   logic                r_done_d;

   logic                w_done_rise;
   logic                w_found;
   logic [CH_W-1:0]     w_win, w_win_inc, w_idx;
   logic [31:0]         w_sum, w_inc_sum;
   logic [DATA_W-1:0]   w_dout [NUM_CH];

   // Unpack the flat FIFO data bus into per-channel words.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign w_dout[g] = ch_fifo_dout[g*DATA_W +: DATA_W];
   end

   // Only a 0->1 transition of tx_done completes a character.
   assign w_done_rise = tx_done & ~r_done_d;

   // Round-robin search starting at r_rr for an enabled, non-empty channel.
   always_comb begin
      w_found   = 1'b0;
      w_win     = '0;
      w_idx     = '0;
      w_sum     = '0;
      w_inc_sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_sum = 32'(r_rr) + 32'(i);
         if (w_sum >= NUM_CH) begin
            w_sum = w_sum - NUM_CH;
         end
         w_idx = CH_W'(w_sum);
         if (!w_found && ch_enable[w_idx] && !ch_fifo_empty[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
      w_inc_sum = 32'(w_win) + 32'd1;
      w_win_inc = (w_inc_sum >= NUM_CH) ? '0 : CH_W'(w_inc_sum);
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_rd_en_nxt = '0;
      w_val_nxt   = r_val;
      w_data_nxt  = r_data;
      w_ch_nxt    = r_ch;
      w_rr_nxt    = r_rr;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_rd_en_nxt = NUM_CH'(1) << w_win;
               w_ch_nxt    = w_win;
               w_rr_nxt    = w_win_inc;
               w_cnt_nxt   = '0;
               if (FWFT != 0) begin
                  // Head word is already on dout; capture it with the grant.
                  w_data_nxt  = w_dout[w_win];
                  w_val_nxt   = 1'b1;
                  w_state_nxt = S_SEND;
               end else begin
                  w_state_nxt = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            // Wait out the FIFO read latency, counted from the pop cycle.
            if (r_cnt == CNT_W'(RD_LAT - 1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_LOAD;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_LOAD: begin
            w_data_nxt  = w_dout[r_ch];
            w_val_nxt   = 1'b1;
            w_state_nxt = S_SEND;
         end
         S_SEND: begin
            if (w_done_rise) begin
               w_val_nxt   = 1'b0;
               w_cnt_nxt   = '0;
               w_state_nxt = (GAP_CYC > 0) ? S_GAP : S_IDLE;
            end
         end
         S_GAP: begin
            if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; tx_done history tracks every cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_rd_en  <= '0;
         r_val    <= 1'b0;
         r_data   <= '0;
         r_ch     <= '0;
         r_rr     <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done_d <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_rd_en  <= w_rd_en_nxt;
         r_val    <= w_val_nxt;
         r_data   <= w_data_nxt;
         r_ch     <= w_ch_nxt;
         r_rr     <= w_rr_nxt;
         r_cnt    <= w_cnt_nxt;
         r_busy   <= (w_state_nxt != S_IDLE);
         r_done_d <= tx_done;
      end
   end

   assign ch_fifo_rd_en = r_rd_en;
   assign tx_data_val   = r_val;
   assign tx_data       = r_data;
   assign tx_ch         = r_ch;
   assign busy          = r_busy;

endmodule

// File: tb/tb_ui_char_seq_mc.sv
// tb_ui_char_seq_mc: scoreboard bench for ui_char_seq_mc. Four instances cover the
// default, FWFT, RD_LAT=3 and GAP_CYC=10 configurations; a behavioural FIFO model
// serves whichever instance is selected.
module tb_ui_char_seq_mc;

   typedef struct packed {
      logic [1:0] ch;
      logic [7:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  ch_en;
   logic [3:0]  ch_empty;
   logic [31:0] ch_dout;
   logic        tx_done;

   logic [3:0]  rd_o   [4];
   logic        val_o  [4];
   logic [7:0]  data_o [4];
   logic [1:0]  ch_o   [4];
   logic        busy_o [4];

   logic [1:0]  sel;
   logic [3:0]  s_rd;
   logic        s_val;
   logic [7:0]  s_data;
   logic [1:0]  s_ch;
   logic        s_busy;

   // FIFO model state
   logic [7:0]  fmem [4][16];
   logic [3:0]  wp   [4];
   logic [3:0]  rp   [4];
   logic [7:0]  dl   [4][4];
   logic        fwft_mode;
   logic [1:0]  lat_idx;
   logic        flush;

   exp_t        exp_q [$];
   int          n_checks;
   int          n_errors;
   int          rd_cnt = 0;
   int          multi  = 0;

   always #5 clk = ~clk;

   ui_char_seq_mc #(.NUM_CH(4), .DATA_W(8), .FWFT(0), .RD_LAT(1), .GAP_CYC(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .ch_enable(ch_en), .ch_fifo_empty(ch_empty),
      .ch_fifo_rd_en(rd_o[0]), .ch_fifo_dout(ch_dout), .tx_data_val(val_o[0]),
      .tx_data(data_o[0]), .tx_ch(ch_o[0]), .tx_done(tx_done), .busy(busy_o[0]));

   ui_char_seq_mc #(.NUM_CH(4), .DATA_W(8), .FWFT(1), .RD_LAT(1), .GAP_CYC(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ch_enable(ch_en), .ch_fifo_empty(ch_empty),
      .ch_fifo_rd_en(rd_o[1]), .ch_fifo_dout(ch_dout), .tx_data_val(val_o[1]),
      .tx_data(data_o[1]), .tx_ch(ch_o[1]), .tx_done(tx_done), .busy(busy_o[1]));

   ui_char_seq_mc #(.NUM_CH(4), .DATA_W(8), .FWFT(0), .RD_LAT(3), .GAP_CYC(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .ch_enable(ch_en), .ch_fifo_empty(ch_empty),
      .ch_fifo_rd_en(rd_o[2]), .ch_fifo_dout(ch_dout), .tx_data_val(val_o[2]),
      .tx_data(data_o[2]), .tx_ch(ch_o[2]), .tx_done(tx_done), .busy(busy_o[2]));

   ui_char_seq_mc #(.NUM_CH(4), .DATA_W(8), .FWFT(0), .RD_LAT(1), .GAP_CYC(10)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .ch_enable(ch_en), .ch_fifo_empty(ch_empty),
      .ch_fifo_rd_en(rd_o[3]), .ch_fifo_dout(ch_dout), .tx_data_val(val_o[3]),
      .tx_data(data_o[3]), .tx_ch(ch_o[3]), .tx_done(tx_done), .busy(busy_o[3]));

   // Observe the instance under test.
   always_comb begin
      s_rd   = rd_o[sel];
      s_val  = val_o[sel];
      s_data = data_o[sel];
      s_ch   = ch_o[sel];
      s_busy = busy_o[sel];
   end

   // FIFO model: empty/dout presentation.
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         ch_empty[c]       = (rp[c] == wp[c]);
         ch_dout[c*8 +: 8] = fwft_mode ? fmem[c][rp[c]] : dl[c][lat_idx];
      end
   end

   // FIFO model: pop on rd_en; standard data appears after lat_idx+1 cycles.
   always @(posedge clk) begin
      for (int c = 0; c < 4; c++) begin
         if (flush) begin
            rp[c] <= wp[c];
         end else if (s_rd[c] && (rp[c] != wp[c])) begin
            dl[c][0] <= fmem[c][rp[c]];
            rp[c]    <= rp[c] + 4'd1;
         end
         for (int s = 1; s < 4; s++) begin
            dl[c][s] <= dl[c][s-1];
         end
      end
   end

   // Pop-strobe monitor.
   always @(negedge clk) begin
      if (s_rd != 4'd0) rd_cnt++;
      if ($countones(s_rd) > 1) multi++;
   end

   task automatic push_char(input logic [1:0] c, input logic [7:0] d, input bit expect_it);
      exp_t e;
      fmem[c][wp[c]] = d;
      wp[c] = wp[c] + 4'd1;
      if (expect_it) begin
         e.ch   = c;
         e.data = d;
         exp_q.push_back(e);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      tx_done = 1'b0;
      flush   = 1'b1;
      repeat (2) @(negedge clk);
      flush   = 1'b0;
      exp_q.delete();
      rst_n   = 1'b1;
   endtask

   // Waits (bounded) for tx_data_val; n = negedges waited.
   task automatic wait_val(input int budget, output int n, output bit to);
      n  = 0;
      to = 1'b0;
      while (s_val !== 1'b1) begin
         @(negedge clk);
         n++;
         if (n >= budget) begin
            to = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      sel       = 2'd0;
      fwft_mode = 1'b0;
      lat_idx   = 2'd0;
      @(negedge clk);
      rst_n = 1'b0;
      flush = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (s_val !== 1'b0) begin n_errors++; $display("FAIL reset_val got %b exp 0", s_val); end
      n_checks++; if (s_rd !== 4'd0) begin n_errors++; $display("FAIL reset_rd got %b exp 0000", s_rd); end
      n_checks++; if (s_data !== 8'd0) begin n_errors++; $display("FAIL reset_data got %h exp 00", s_data); end
      n_checks++; if (s_ch !== 2'd0) begin n_errors++; $display("FAIL reset_ch got %0d exp 0", s_ch); end
      n_checks++; if (s_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", s_busy); end
      flush = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (s_busy !== 1'b0 || s_rd !== 4'd0) begin
         n_errors++; $display("FAIL idle_empty got busy=%b rd=%b exp 0/0000", s_busy, s_rd);
      end
   endtask

   task automatic test_single();
      exp_t e;
      sel = 2'd0; fwft_mode = 1'b0; lat_idx = 2'd0;
      do_reset();
      push_char(2'd2, 8'h41, 1'b1);
      @(negedge clk);  // t+1
      n_checks++; if (s_rd !== 4'b0100) begin n_errors++; $display("FAIL single_rd_t1 got %b exp 0100", s_rd); end
      n_checks++; if (s_busy !== 1'b1) begin n_errors++; $display("FAIL single_busy got %b exp 1", s_busy); end
      @(negedge clk);  // t+2
      n_checks++; if (s_rd !== 4'd0 || s_val !== 1'b0) begin
         n_errors++; $display("FAIL single_t2 got rd=%b val=%b exp 0000/0", s_rd, s_val);
      end
      @(negedge clk);  // t+3
      n_checks++; if (s_val !== 1'b1) begin n_errors++; $display("FAIL single_val_t3 got %b exp 1", s_val); end
      e = exp_q.pop_front();
      n_checks++; if (s_data !== e.data || s_ch !== e.ch) begin
         n_errors++; $display("FAIL single_char got %h/%0d exp %h/%0d", s_data, s_ch, e.data, e.ch);
      end
      tx_done = 1'b1;
      @(negedge clk);
      n_checks++; if (s_val !== 1'b0 || s_busy !== 1'b0) begin
         n_errors++; $display("FAIL single_done got val=%b busy=%b exp 0/0", s_val, s_busy);
      end
      tx_done = 1'b0;
   endtask

   task automatic test_round_robin();
      exp_t e;
      int   n, rd0, mh0;
      bit   to;
      sel = 2'd0; fwft_mode = 1'b0; lat_idx = 2'd0;
      do_reset();
      rd0 = rd_cnt;
      mh0 = multi;
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c < 4; c++) begin
            push_char(2'(c), 8'(8'h30 + 16*c + k), 1'b1);
         end
      end
      for (int i = 0; i < 12; i++) begin
         wait_val(20, n, to);
         n_checks++;
         if (to || exp_q.size() == 0) begin
            n_errors++; $display("FAIL rr_timeout char %0d got none exp valid", i);
         end else begin
            e = exp_q.pop_front();
            if (s_ch !== e.ch || s_data !== e.data) begin
               n_errors++; $display("FAIL rr_order char %0d got %0d/%h exp %0d/%h", i, s_ch, s_data, e.ch, e.data);
            end
         end
         tx_done = 1'b1;
         @(negedge clk);
         tx_done = 1'b0;
      end
      repeat (5) @(negedge clk);
      n_checks++; if (rd_cnt - rd0 != 12) begin n_errors++; $display("FAIL rr_pulses got %0d exp 12", rd_cnt - rd0); end
      n_checks++; if (multi - mh0 != 0) begin n_errors++; $display("FAIL rr_onehot got %0d exp 0", multi - mh0); end
   endtask

   task automatic test_done_level();
      exp_t e;
      int   n, rd0;
      bit   to;
      sel = 2'd0; fwft_mode = 1'b0; lat_idx = 2'd0;
      do_reset();
      rd0 = rd_cnt;
      tx_done = 1'b1;
      push_char(2'd1, 8'h77, 1'b1);
      wait_val(20, n, to);
      e = exp_q.pop_front();
      n_checks++; if (to || s_data !== e.data || s_ch !== e.ch) begin
         n_errors++; $display("FAIL lvl_char got %h/%0d exp %h/%0d", s_data, s_ch, e.data, e.ch);
      end
      repeat (5) @(negedge clk);
      n_checks++; if (s_val !== 1'b1) begin n_errors++; $display("FAIL lvl_hold got %b exp 1", s_val); end
      tx_done = 1'b0;
      @(negedge clk);
      n_checks++; if (s_val !== 1'b1) begin n_errors++; $display("FAIL lvl_low got %b exp 1", s_val); end
      tx_done = 1'b1;
      @(negedge clk);
      n_checks++; if (s_val !== 1'b0) begin n_errors++; $display("FAIL lvl_edge got %b exp 0", s_val); end
      repeat (4) @(negedge clk);
      n_checks++; if (s_val !== 1'b0 || s_busy !== 1'b0 || rd_cnt - rd0 != 1) begin
         n_errors++; $display("FAIL lvl_once got val=%b busy=%b pops=%0d exp 0/0/1", s_val, s_busy, rd_cnt - rd0);
      end
      tx_done = 1'b0;
   endtask

   task automatic test_fwft();
      exp_t e;
      sel = 2'd1; fwft_mode = 1'b1; lat_idx = 2'd0;
      do_reset();
      push_char(2'd1, 8'h5A, 1'b1);
      @(negedge clk);  // t+1
      n_checks++; if (s_rd !== 4'b0010 || s_val !== 1'b1) begin
         n_errors++; $display("FAIL fwft_t1 got rd=%b val=%b exp 0010/1", s_rd, s_val);
      end
      e = exp_q.pop_front();
      n_checks++; if (s_data !== e.data || s_ch !== e.ch) begin
         n_errors++; $display("FAIL fwft_char got %h/%0d exp %h/%0d", s_data, s_ch, e.data, e.ch);
      end
      @(negedge clk);
      n_checks++; if (s_rd !== 4'd0 || s_val !== 1'b1) begin
         n_errors++; $display("FAIL fwft_t2 got rd=%b val=%b exp 0000/1", s_rd, s_val);
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      n_checks++; if (s_val !== 1'b0) begin n_errors++; $display("FAIL fwft_done got %b exp 0", s_val); end
   endtask

   task automatic test_rd_lat3();
      exp_t e;
      int   n;
      bit   to;
      sel = 2'd2; fwft_mode = 1'b0; lat_idx = 2'd2;
      do_reset();
      push_char(2'd3, 8'hC3, 1'b1);
      wait_val(20, n, to);
      n_checks++; if (to || n != 5) begin n_errors++; $display("FAIL lat3_latency got %0d exp 5", n); end
      e = exp_q.pop_front();
      n_checks++; if (s_data !== e.data || s_ch !== e.ch) begin
         n_errors++; $display("FAIL lat3_char got %h/%0d exp %h/%0d", s_data, s_ch, e.data, e.ch);
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic test_gap();
      exp_t e;
      int   n, busy_low;
      bit   to, val1;
      sel = 2'd3; fwft_mode = 1'b0; lat_idx = 2'd0;
      do_reset();
      push_char(2'd0, 8'hA1, 1'b1);
      push_char(2'd0, 8'hA2, 1'b1);
      wait_val(20, n, to);
      e = exp_q.pop_front();
      n_checks++; if (to || s_data !== e.data) begin n_errors++; $display("FAIL gap_first got %h exp %h", s_data, e.data); end
      tx_done  = 1'b1;
      n        = 0;
      busy_low = 0;
      val1     = 1'b1;
      // rd_en should rise 11 clock edges after the edge that samples tx_done.
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            tx_done = 1'b0;
            val1    = s_val;
         end
         if (n <= 10 && s_busy !== 1'b1) busy_low++;
         if (s_rd != 4'd0) break;
      end
      n_checks++; if (val1 !== 1'b0) begin n_errors++; $display("FAIL gap_val_drop got %b exp 0", val1); end
      n_checks++; if (n != 12) begin n_errors++; $display("FAIL gap_second_rd got %0d exp 12", n); end
      n_checks++; if (busy_low != 0) begin n_errors++; $display("FAIL gap_busy got %0d low cycles exp 0", busy_low); end
      wait_val(20, n, to);
      e = exp_q.pop_front();
      n_checks++; if (to || s_data !== e.data || s_ch !== e.ch) begin
         n_errors++; $display("FAIL gap_second got %h/%0d exp %h/%0d", s_data, s_ch, e.data, e.ch);
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic test_reset_mid_send();
      exp_t e;
      int   n;
      bit   to;
      sel = 2'd0; fwft_mode = 1'b0; lat_idx = 2'd0;
      do_reset();
      push_char(2'd2, 8'hB2, 1'b1);
      wait_val(20, n, to);
      e = exp_q.pop_front();
      n_checks++; if (to || s_ch !== e.ch) begin n_errors++; $display("FAIL rst_pre got %0d exp %0d", s_ch, e.ch); end
      // Round-robin pointer now sits at 3; only reset brings ch0 ahead of ch3.
      push_char(2'd0, 8'hB0, 1'b0);
      push_char(2'd3, 8'hB3, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (s_val !== 1'b0 || s_rd !== 4'd0 || s_busy !== 1'b0 || s_data !== 8'd0 || s_ch !== 2'd0) begin
         n_errors++; $display("FAIL rst_mid got val=%b rd=%b busy=%b data=%h ch=%0d exp all 0", s_val, s_rd, s_busy, s_data, s_ch);
      end
      e.ch = 2'd0; e.data = 8'hB0; exp_q.push_back(e);
      e.ch = 2'd3; e.data = 8'hB3; exp_q.push_back(e);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         wait_val(20, n, to);
         n_checks++;
         if (to || exp_q.size() == 0) begin
            n_errors++; $display("FAIL rst_after_timeout char %0d got none exp valid", i);
         end else begin
            e = exp_q.pop_front();
            if (s_ch !== e.ch || s_data !== e.data) begin
               n_errors++; $display("FAIL rst_after_order char %0d got %0d/%h exp %0d/%h", i, s_ch, s_data, e.ch, e.data);
            end
         end
         tx_done = 1'b1;
         @(negedge clk);
         tx_done = 1'b0;
      end
      repeat (10) @(negedge clk);
      n_checks++; if (s_val !== 1'b0 || s_busy !== 1'b0) begin
         n_errors++; $display("FAIL rst_no_repop got val=%b busy=%b exp 0/0", s_val, s_busy);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      tx_done   = 1'b0;
      ch_en     = 4'hF;
      flush     = 1'b0;
      sel       = 2'd0;
      fwft_mode = 1'b0;
      lat_idx   = 2'd0;
      for (int c = 0; c < 4; c++) wp[c] = 4'd0;
      test_reset();
      test_single();
      test_round_robin();
      test_done_level();
      test_fwft();
      test_rd_lat3();
      test_gap();
      test_reset_mid_send();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
